// File: rtl/rr_mux_scheduler.sv
// Round-robin scheduler sharing one registered output slot between N_REQ
// valid/ready requesters. The winner's word and index are captured into the
// output register; a rotating pointer gives the most recent winner lowest
// priority on the next arbitration.
module rr_mux_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           in_valid,
  input  logic [N_REQ*WIDTH-1:0]     in_data,
  output logic [N_REQ-1:0]           in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(N_REQ)-1:0]   out_sel,
  output logic [CNT_W-1:0]           xfer_cnt
);

  localparam int unsigned SEL_W = $clog2(N_REQ);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e             r_state;
  logic [WIDTH-1:0]   r_data;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_slot_free;
  logic               w_found;
  logic               w_accept;
  logic               w_drain;
  logic [SEL_W-1:0]   w_win;
  logic [SEL_W-1:0]   w_cand;
  logic [SEL_W-1:0]   w_ptr_next;
  logic [31:0]        w_sum;
  logic [WIDTH-1:0]   w_data;

  assign out_valid   = (r_state == StFull);
  assign out_data    = r_data;
  assign out_sel     = r_sel;
  assign xfer_cnt    = r_cnt;
  assign w_slot_free = !out_valid || out_ready;
  assign w_accept    = w_found && w_slot_free;
  assign w_drain     = out_valid && out_ready;

  // Pointer wraps explicitly so non-power-of-two N_REQ never reaches N_REQ.
  assign w_ptr_next  = (w_win == SEL_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;

  // Scan requesters starting at the pointer; first valid one wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_sum = 32'(r_ptr) + k;
      if (w_sum >= N_REQ) begin
        w_sum = w_sum - N_REQ;
      end
      w_cand = w_sum[SEL_W-1:0];
      if (!w_found && in_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Grant and data mux for the winner.
  always_comb begin
    in_ready = '0;
    w_data   = '0;
    if (w_accept) begin
      in_ready[w_win] = 1'b1;
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_win == SEL_W'(i)) begin
        w_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output slot state, captured word, pointer and transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StEmpty;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_drain) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        // A same-cycle drain and accept replaces the word: full throughput.
        r_state <= StFull;
        r_data  <= w_data;
        r_sel   <= w_win;
        r_ptr   <= w_ptr_next;
      end else if (w_drain) begin
        r_state <= StEmpty;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// Directed and randomised checks for rr_mux_scheduler (N_REQ=4, WIDTH=8).
// A second instance with CNT_W=4 shares the stimulus to observe counter wrap.
module tb_rr_mux_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic [15:0] xfer_cnt;

  logic [3:0]  s_in_ready;
  logic        s_out_valid;
  logic [7:0]  s_out_data;
  logic [1:0]  s_out_sel;
  logic [3:0]  s_xfer_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_mux_scheduler #(.N_REQ(4), .WIDTH(8), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .xfer_cnt  (xfer_cnt)
  );

  rr_mux_scheduler #(.N_REQ(4), .WIDTH(8), .CNT_W(4)) u_dut_small (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (s_in_ready),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .out_sel   (s_out_sel),
    .xfer_cnt  (s_xfer_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_ramp_data();
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
  endtask

  // Random-phase bench state
  logic [5:0] seq     [4];
  logic [5:0] exp_seq [4];
  int         wait_cnt[4];
  int         mptr;
  int         n_acc;
  int         n_out;
  logic [3:0] exp_rdy;
  int         mwin;
  bit         mfound;
  bit         do_acc;
  int         acc_w;

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // 1. Reset and idle
    do_reset();
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_in_ready",  32'(in_ready),  0);
    check_eq("rst_xfer_cnt",  32'(xfer_cnt),  0);
    check_eq("rst_out_data",  32'(out_data),  0);
    check_eq("rst_out_sel",   32'(out_sel),   0);

    // 2. Single requester
    in_data   = 32'h00A5_0000;
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    check_eq("single_in_ready", 32'(in_ready), 4'b0100);
    tick();
    in_valid = '0;
    #1;
    check_eq("single_out_valid", 32'(out_valid), 1);
    check_eq("single_out_data",  32'(out_data),  8'hA5);
    check_eq("single_out_sel",   32'(out_sel),   2);
    check_eq("single_cnt_pre",   32'(xfer_cnt),  0);
    tick();
    check_eq("single_drained",   32'(out_valid), 0);
    check_eq("single_cnt_post",  32'(xfer_cnt),  1);
    in_valid = 4'b1111;
    #1;
    check_eq("single_ptr3", 32'(in_ready), 4'b1000);
    in_valid = '0;

    // 3. All valid, streaming
    do_reset();
    set_ramp_data();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("stream_rdy%0d", k), 32'(in_ready), 32'(1) << (k % 4));
      tick();
      check_eq($sformatf("stream_valid%0d", k), 32'(out_valid), 1);
      check_eq($sformatf("stream_sel%0d", k),   32'(out_sel),   k % 4);
      check_eq($sformatf("stream_data%0d", k),  32'(out_data),  8'h10 + (k % 4));
    end
    check_eq("stream_cnt7", 32'(xfer_cnt), 7);
    in_valid = '0;
    tick();
    check_eq("stream_cnt8",  32'(xfer_cnt),  8);
    check_eq("stream_empty", 32'(out_valid), 0);

    // 4. Backpressure
    do_reset();
    set_ramp_data();
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #1;
    check_eq("bp_first_rdy", 32'(in_ready), 4'b0001);
    tick();
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("bp_valid%0d", k), 32'(out_valid), 1);
      check_eq($sformatf("bp_data%0d", k),  32'(out_data),  8'h10);
      check_eq($sformatf("bp_sel%0d", k),   32'(out_sel),   0);
      check_eq($sformatf("bp_rdy%0d", k),   32'(in_ready),  0);
      check_eq($sformatf("bp_cnt%0d", k),   32'(xfer_cnt),  0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_rdy", 32'(in_ready), 4'b0010);
    tick();
    check_eq("bp_release_sel",  32'(out_sel),  1);
    check_eq("bp_release_data", 32'(out_data), 8'h11);
    check_eq("bp_release_cnt",  32'(xfer_cnt), 1);

    // 5. Fairness from ptr=1 with 1001
    do_reset();
    set_ramp_data();
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    tick();
    in_valid = 4'b1001;
    #1;
    check_eq("fair_w3a", 32'(in_ready), 4'b1000);
    tick();
    check_eq("fair_sel3a", 32'(out_sel),  3);
    check_eq("fair_w0",    32'(in_ready), 4'b0001);
    tick();
    check_eq("fair_sel0",  32'(out_sel),  0);
    check_eq("fair_w3b",   32'(in_ready), 4'b1000);

    // 1b. Reset while FULL discards the held word
    in_valid  = '0;
    out_ready = 1'b0;
    #1;
    check_eq("midrst_full", 32'(out_valid), 1);
    rst = 1'b1;
    tick();
    check_eq("midrst_valid", 32'(out_valid), 0);
    check_eq("midrst_data",  32'(out_data),  0);
    check_eq("midrst_sel",   32'(out_sel),   0);
    rst = 1'b0;

    // 6a. Counter wrap on the CNT_W=4 instance
    do_reset();
    set_ramp_data();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 18; k++) tick();
    check_eq("wrap_cnt16", 32'(xfer_cnt),   17);
    check_eq("wrap_cnt4",  32'(s_xfer_cnt), 1);

    // 6b. Random valid/ready with per-source ordering scoreboard
    do_reset();
    mptr  = 0;
    n_acc = 0;
    n_out = 0;
    for (int i = 0; i < 4; i++) begin
      seq[i]      = '0;
      exp_seq[i]  = '0;
      wait_cnt[i] = 0;
    end
    for (int c = 0; c < 2010; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!in_valid[i] && c < 2000 && $urandom_range(0, 2) != 0) begin
          in_valid[i]      = 1'b1;
          in_data[i*8 +: 8] = {2'(i), seq[i]};
        end
      end
      out_ready = (c >= 2000) || ($urandom_range(0, 3) != 0);
      #1;
      mfound = 1'b0;
      mwin   = 0;
      for (int k = 0; k < 4; k++) begin
        if (!mfound && in_valid[(mptr + k) % 4]) begin
          mfound = 1'b1;
          mwin   = (mptr + k) % 4;
        end
      end
      do_acc  = mfound && (!out_valid || out_ready);
      exp_rdy = do_acc ? 4'(1 << mwin) : 4'b0000;
      check_eq("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
      if (out_valid && out_ready) begin
        check_eq("rand_sel_tag", 32'(out_sel), 32'(out_data[7:6]));
        check_eq("rand_order", 32'(out_data[5:0]), 32'(exp_seq[out_data[7:6]]));
        exp_seq[out_data[7:6]] = exp_seq[out_data[7:6]] + 1'b1;
        n_out++;
      end
      acc_w = mwin;
      if (do_acc) begin
        check_eq("rand_fair", 32'(wait_cnt[acc_w] <= 3), 1);
        for (int i = 0; i < 4; i++) begin
          if (i != acc_w && in_valid[i]) wait_cnt[i]++;
        end
        wait_cnt[acc_w] = 0;
        mptr = (acc_w + 1) % 4;
        n_acc++;
      end
      tick();
      if (do_acc) begin
        in_valid[acc_w] = 1'b0;
        seq[acc_w]      = seq[acc_w] + 1'b1;
      end
    end
    check_eq("rand_no_loss", 32'(n_out), 32'(n_acc));
    check_eq("rand_drained", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rand_seq%0d", i), 32'(exp_seq[i]), 32'(seq[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
